bdi_compressor_pipe: RTL and testbench
======================================

BDI_COMPRESSOR_PIPE -- requirements
Module: bdi_compressor_pipe

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning the cache line width in bits; it is a multiple of 64 and at least 128.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the line statistics counter.
REQ-003 SHALL derive NB = LINE_W/8 (line bytes) and SZ_W = clog2(NB)+1.
REQ-004 SHALL run on one clock and one reset: the reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  in_line is valid this cycle.
REQ-008 in_ready  output  1  the block accepts in_line this cycle.
REQ-009 in_line  input  LINE_W  uncompressed line; byte 0 is bits [7:0], and word i of size B occupies bits [8B(i+1)-1:8Bi].
REQ-010 out_valid  output  1  compressed result is valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_code  output  4  encoding selected.
REQ-013 out_size  output  SZ_W  compressed size in bytes.
REQ-014 out_data  output  LINE_W  packed compressed line.
REQ-015 stat_lines  output  CNT_W  count of lines emitted.

Function
REQ-016 Encodings SHALL be: 0 ZERO; 1 REP8 (all 64-bit words equal); 2 B8D1; 3 B8D2; 4 B8D4; 5 B4D1; 6 B4D2; 7 B2D1; 15 UNCOMP. Codes 8-14 are never produced.
REQ-017 For BbDd, the base SHALL be word 0 at size b, N = NB/b, delta_i = word_i - base (mod 2^(8b)), and delta_i SHALL fit d signed bytes (sign-extension back to 8b bytes reproduces it) for every i.
REQ-018 Sizes SHALL be ZERO=1, REP8=8, BbDd = b+N*d, UNCOMP=NB; for LINE_W=256 these give B8D1=12, B8D2=16, B8D4=24, B4D1=12, B4D2=20, B2D1=18.
REQ-019 Selection SHALL take the smallest-size valid encoding; ties go to the lower code, so ZERO beats REP8 on an all-zero line.
REQ-020 out_data SHALL be packed as follows: ZERO gives all zeros; REP8 gives word0 in [63:0]; BbDd gives the base in [8b-1:0], then delta_0..delta_{N-1}, each d bytes, ascending; UNCOMP gives in_line unchanged. All unused upper bits SHALL be 0.
REQ-021 The pipeline SHALL have 2 register stages: S1 registers the line plus per-encoding fit flags, and S2 registers the selection and packed output. Latency from accept to out_valid is 2 cycles.
REQ-022 Handshake: a transfer occurs when valid&&ready; adv2 = !out_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1. in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 While out_valid && !out_ready, out_code, out_size and out_data SHALL hold stable.
REQ-024 Full throughput SHALL be one line per cycle when out_ready is held at 1.
REQ-025 Simultaneous S2 drain and S1 refill in the same cycle SHALL lose no line and duplicate no line.
REQ-026 stat_lines SHALL increment on each out_valid&&out_ready and wrap modulo 2^CNT_W.

Reset
REQ-027 While rst is high: s1_valid=0, out_valid=0, out_code=0, out_size=0, out_data=0, stat_lines=0. in_ready=1 is permitted during reset.
REQ-028 Asserting rst mid-operation SHALL discard all in-flight lines with no output transfer; the first line accepted after release appears 2 cycles later.

Verification (LINE_W=256)
REQ-029 Scenario: all-zero line -> code 0, size 1, data 0.
REQ-030 Scenario: four 64-bit words 0xA5A5A5A5A5A5A5A5 -> code 1, size 8, data[63:0]=0xA5A5A5A5A5A5A5A5, rest 0.
REQ-031 Scenario: 64-bit words (word0..3) 0xFF,0x22,0x44,0x66 -> code 3, size 16, deltas 0x0000,0xFF23,0xFF45,0xFF67.
REQ-032 Scenario: 16-bit words 0x0000,0x0005,...,0x004B (step 5) -> code 7, size 18, base 0x0000 then deltas 0x00,0x05,...,0x4B.
REQ-033 Scenario: 32-bit words 0x00,0x22,...,0x88 -> B4D1 fails because 0x88>127 -> code 6, size 20; a random incompressible line -> code 15, size 32, data equal to input.
REQ-034 Scenario: stream 6 lines with out_ready low for cycles 3-5 -> in_ready drops once both stages are full, outputs stay stable, order is preserved, and stat_lines=6. Pulsing rst with 2 lines in flight -> out_valid=0 next cycle and stat_lines=0.

Source files
------------

// File: rtl/bdi_compressor_pipe.sv
// Base-Delta-Immediate cache line compressor, two register stages with valid/ready flow control.
// Stage 1 registers the line with per-encoding fit flags; stage 2 registers the chosen code, size and packed line.
module bdi_compressor_pipe #(
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16,
  localparam int NB    = LINE_W / 8,
  localparam int SZ_W  = $clog2(NB) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] in_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_code,
  output logic [SZ_W-1:0]   out_size,
  output logic [LINE_W-1:0] out_data,
  output logic [CNT_W-1:0]  stat_lines
);

  localparam int N8 = NB / 8;
  localparam int N4 = NB / 4;
  localparam int N2 = NB / 2;

  logic              adv1, adv2;
  logic              vld_p1;
  logic [LINE_W-1:0] line_p1;
  logic [7:0]        fit_nx, fit_p1;
  logic              found;
  logic [3:0]        code_nx;
  logic [SZ_W-1:0]   size_nx;
  logic [LINE_W-1:0] data_nx;

  function automatic logic [63:0] word_at(input logic [LINE_W-1:0] line, input int b, input int i);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++)
      if (k < b) w[8*k +: 8] = line[8*(b*i+k) +: 8];
    return w;
  endfunction

  // A delta fits d signed bytes when bits [8b-1:8d-1] are all copies of its sign bit.
  function automatic logic fits_bd(input logic [LINE_W-1:0] line, input int b, input int d);
    logic        ok;
    logic [63:0] base, dl;
    ok   = 1'b1;
    base = word_at(line, b, 0);
    for (int i = 0; i < NB; i++) begin
      if (i < NB / b) begin
        dl = word_at(line, b, i) - base;
        for (int k = 0; k < 64; k++)
          if (k >= 8*d && k < 8*b && dl[k] != dl[8*d-1]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic [LINE_W-1:0] pack_bd(input logic [LINE_W-1:0] line, input int b, input int d);
    logic [LINE_W-1:0] r;
    logic [63:0]       base, dl;
    r    = '0;
    base = word_at(line, b, 0);
    for (int k = 0; k < 8; k++)
      if (k < b) r[8*k +: 8] = base[8*k +: 8];
    for (int i = 0; i < NB; i++) begin
      if (i < NB / b) begin
        dl = word_at(line, b, i) - base;
        for (int k = 0; k < 4; k++)
          if (k < d) r[8*(b + d*i + k) +: 8] = dl[8*k +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [SZ_W-1:0] size_of(input logic [3:0] code);
    int s;
    case (code)
      4'd0:    s = 1;
      4'd1:    s = 8;
      4'd2:    s = 8 + N8;
      4'd3:    s = 8 + 2*N8;
      4'd4:    s = 8 + 4*N8;
      4'd5:    s = 4 + N4;
      4'd6:    s = 4 + 2*N4;
      4'd7:    s = 2 + N2;
      default: s = NB;
    endcase
    return SZ_W'(s);
  endfunction

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  always_comb begin
    fit_nx    = '0;
    fit_nx[0] = ~|in_line;
    fit_nx[1] = 1'b1;
    for (int i = 0; i < N8; i++)
      if (in_line[64*i +: 64] != in_line[63:0]) fit_nx[1] = 1'b0;
    fit_nx[2] = fits_bd(in_line, 8, 1);
    fit_nx[3] = fits_bd(in_line, 8, 2);
    fit_nx[4] = fits_bd(in_line, 8, 4);
    fit_nx[5] = fits_bd(in_line, 4, 1);
    fit_nx[6] = fits_bd(in_line, 4, 2);
    fit_nx[7] = fits_bd(in_line, 2, 1);
  end

  // ---- stage 1: line and fit flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       vld_p1 <= 1'b0;
    else if (adv1) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      line_p1 <= in_line;
      fit_p1  <= fit_nx;
    end
  end

  // Codes are scanned in ascending order with a strict compare, so ties keep the lower code.
  always_comb begin
    found   = 1'b0;
    code_nx = 4'd15;
    size_nx = SZ_W'(NB);
    for (int c = 0; c < 8; c++) begin
      if (fit_p1[c] && (!found || size_of(4'(c)) < size_nx)) begin
        found   = 1'b1;
        code_nx = 4'(c);
        size_nx = size_of(4'(c));
      end
    end
    data_nx = line_p1;
    case (code_nx)
      4'd0:    data_nx = '0;
      4'd1:    data_nx = LINE_W'(line_p1[63:0]);
      4'd2:    data_nx = pack_bd(line_p1, 8, 1);
      4'd3:    data_nx = pack_bd(line_p1, 8, 2);
      4'd4:    data_nx = pack_bd(line_p1, 8, 4);
      4'd5:    data_nx = pack_bd(line_p1, 4, 1);
      4'd6:    data_nx = pack_bd(line_p1, 4, 2);
      4'd7:    data_nx = pack_bd(line_p1, 2, 1);
      default: data_nx = line_p1;
    endcase
  end

  // ---- stage 2: selected encoding and packed line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_size  <= '0;
      out_data  <= '0;
    end else if (adv2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_code <= code_nx;
        out_size <= size_nx;
        out_data <= data_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        stat_lines <= '0;
    else if (out_valid && out_ready) stat_lines <= stat_lines + 1'b1;
  end

endmodule

// File: tb/tb_bdi_compressor_pipe.sv
// Bench for bdi_compressor_pipe (LINE_W=256): directed lines, random traffic against a
// reference model, backpressure and mid-flight reset.
module tb_bdi_compressor_pipe;
  localparam int LINE_W = 256;
  localparam int CNT_W  = 16;
  localparam int SZ_W   = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [LINE_W-1:0] in_line, out_data;
  logic [3:0]        out_code;
  logic [SZ_W-1:0]   out_size;
  logic [CNT_W-1:0]  stat_lines;

  bdi_compressor_pipe #(.LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_size(out_size),
    .out_data(out_data), .stat_lines(stat_lines)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   code;
    logic [5:0]   size;
    logic [255:0] data;
  } res_t;

  res_t         q[$];
  res_t         held;
  int           checks = 0;
  int           errors = 0;
  logic [15:0]  exp_stat;
  logic         hold_pending, acc, stall_seen;
  logic [255:0] l, d, cur;
  logic [255:0] s_lines[6];
  int           sent;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: try every encoding with signed range arithmetic, keep the smallest (earliest on ties).
  function automatic res_t model(input logic [255:0] ln);
    res_t         r;
    int           bs[8] = '{0, 0, 8, 8, 8, 4, 4, 2};
    int           ds[8] = '{0, 0, 1, 2, 4, 1, 2, 1};
    int           best, b, dd, sz;
    logic         ok;
    logic [63:0]  wmask, base, w, dl;
    logic [255:0] pk;
    longint       sd, lim;
    best   = 1000;
    r.code = 4'd15; r.size = 6'd32; r.data = ln;
    if (ln == '0) begin
      best = 1; r.code = 4'd0; r.size = 6'd1; r.data = '0;
    end
    if (ln[63:0] == ln[127:64] && ln[63:0] == ln[191:128] && ln[63:0] == ln[255:192] && 8 < best) begin
      best = 8; r.code = 4'd1; r.size = 6'd8; r.data = 256'(ln[63:0]);
    end
    for (int c = 2; c < 8; c++) begin
      b     = bs[c];
      dd    = ds[c];
      wmask = (b == 8) ? '1 : (64'd1 << (8*b)) - 64'd1;
      base  = ln[63:0] & wmask;
      pk    = 256'(base);
      ok    = 1'b1;
      lim   = longint'(1) << (8*dd - 1);
      for (int i = 0; i < 32 / b; i++) begin
        w  = 64'(ln >> (8*b*i)) & wmask;
        dl = (w - base) & wmask;
        if (b == 8) sd = $signed(dl);
        else if (dl >= (64'd1 << (8*b - 1))) sd = longint'(dl) - (longint'(1) << (8*b));
        else sd = longint'(dl);
        if (sd < -lim || sd >= lim) ok = 1'b0;
        pk = pk | (256'(dl & ((64'd1 << (8*dd)) - 64'd1)) << (8*(b + dd*i)));
      end
      sz = b + (32 / b) * dd;
      if (ok && sz < best) begin
        best = sz; r.code = 4'(c); r.size = 6'(sz); r.data = pk;
      end
    end
    return r;
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] ln;
    logic [63:0]  base, wmask, wd;
    longint       dlt;
    int           kind, b, mag;
    int           mags[6] = '{127, 128, 255, 32767, 32768, 2147483647};
    for (int k = 0; k < 8; k++) ln[32*k +: 32] = $urandom();
    kind = $urandom_range(0, 4);
    if (kind == 4) begin
      ln = {4{ln[63:0]}};
      if ($urandom_range(0, 2) == 0) ln = '0;
    end else if (kind > 0) begin
      b     = (kind == 1) ? 8 : (kind == 2) ? 4 : 2;
      wmask = (b == 8) ? '1 : (64'd1 << (8*b)) - 64'd1;
      base  = ln[63:0];
      mag   = mags[$urandom_range(0, 5)];
      ln    = '0;
      for (int i = 0; i < 32 / b; i++) begin
        dlt = longint'($urandom_range(0, mag));
        if ($urandom_range(0, 1) == 1) dlt = -dlt;
        if (i == 0) dlt = 0;
        wd = (base + 64'(dlt)) & wmask;
        ln = ln | (256'(wd) << (8*b*i));
      end
    end
    return ln;
  endfunction

  task automatic cycle();
    res_t e;
    @(negedge clk);
    acc = 1'b0;
    check("stat", 256'(stat_lines), 256'(exp_stat));
    if (hold_pending) begin
      check("hold_vld", 256'(out_valid), 256'(1'b1));
      check("hold_code", 256'(out_code), 256'(held.code));
      check("hold_size", 256'(out_size), 256'(held.size));
      check("hold_data", out_data, held.data);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", 256'(out_valid), 256'(1'b0));
      else begin
        e = q.pop_front();
        check("code", 256'(out_code), 256'(e.code));
        check("size", 256'(out_size), 256'(e.size));
        check("data", out_data, e.data);
      end
      exp_stat = exp_stat + 16'd1;
    end
    hold_pending = out_valid && !out_ready;
    held.code    = out_code;
    held.size    = out_size;
    held.data    = out_data;
    if (in_valid && !in_ready) stall_seen = 1'b1;
    if (in_valid && in_ready) begin
      q.push_back(model(in_line));
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_dir(input string tag, input logic [255:0] ln, input logic [3:0] code,
                          input logic [5:0] size, input logic [255:0] data);
    in_valid  = 1'b1;
    in_line   = ln;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check({tag, "_vld"}, 256'(out_valid), 256'(1'b1));
    check({tag, "_code"}, 256'(out_code), 256'(code));
    check({tag, "_size"}, 256'(out_size), 256'(size));
    check({tag, "_data"}, out_data, data);
    cycle();
  endtask

  task automatic clear_model();
    q.delete();
    exp_stat     = '0;
    hold_pending = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_line = '0;
    exp_stat = '0; hold_pending = 1'b0; acc = 1'b0; stall_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 256'(out_valid), 256'(1'b0));
    check("rst_code", 256'(out_code), 256'(4'd0));
    check("rst_size", 256'(out_size), 256'(6'd0));
    check("rst_data", out_data, 256'd0);
    check("rst_stat", 256'(stat_lines), 256'(16'd0));
    rst = 1'b0;

    send_dir("zero", 256'd0, 4'd0, 6'd1, 256'd0);
    send_dir("rep8", {4{64'hA5A5A5A5A5A5A5A5}}, 4'd1, 6'd8, 256'(64'hA5A5A5A5A5A5A5A5));
    send_dir("b8d2", {64'h66, 64'h44, 64'h22, 64'hFF}, 4'd3, 6'd16,
             {128'd0, 16'hFF67, 16'hFF45, 16'hFF23, 16'h0000, 64'hFF});
    l = '0; d = '0;
    for (int i = 0; i < 16; i++) begin
      l[16*i +: 16]    = 16'(5*i);
      d[16 + 8*i +: 8] = 8'(5*i);
    end
    send_dir("b2d1", l, 4'd7, 6'd18, d);
    l = {32'h66, 32'h44, 32'h22, 32'h88, 32'h66, 32'h44, 32'h22, 32'h00};
    d = '0;
    for (int i = 0; i < 8; i++) d[32 + 16*i +: 16] = 16'(l[32*i +: 32]);
    send_dir("b4d2", l, 4'd6, 6'd20, d);
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
    send_dir("uncomp", l, 4'd15, 6'd32, l);

    cur = rnd_line();
    for (int n = 0; n < 120; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_line   = cur;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (acc) cur = rnd_line();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10 && q.size() > 0; n++) cycle();
    check("rand_drain", 256'(q.size()), 256'd0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 6; i++) s_lines[i] = rnd_line();
    sent = 0;
    stall_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && (sent < 6 || q.size() > 0); cyc++) begin
      in_valid  = (sent < 6);
      in_line   = s_lines[(sent < 6) ? sent : 5];
      out_ready = !(cyc >= 3 && cyc <= 5);
      cycle();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    check("stream_stall", 256'(stall_seen), 256'(1'b1));
    check("stream_drain", 256'(q.size()), 256'd0);
    check("stream_stat", 256'(stat_lines), 256'(16'd6));

    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_line   = rnd_line();
    cycle();
    in_line = rnd_line();
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    clear_model();
    check("midrst_vld", 256'(out_valid), 256'(1'b0));
    check("midrst_stat", 256'(stat_lines), 256'(16'd0));
    @(posedge clk);
    #1;
    check("midrst_vld_next", 256'(out_valid), 256'(1'b0));
    rst = 1'b0;
    send_dir("post_rst", {4{64'h0123456789ABCDEF}}, 4'd1, 6'd8, 256'(64'h0123456789ABCDEF));
    check("post_rst_stat", 256'(stat_lines), 256'(16'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
